az_sequencer: RTL and testbench
===============================

Name: az_sequencer

Overview:
- Auto-zero sequencer that drives the ADC measurement block through alternating HI (signal) and LO (zero-reference) conversions.
- Switches the input mux and precharge switch, waits a programmable settle time, and triggers the ADC with a start pulse.
- Detects completion from the ADC's done flag and emits a per-phase sample strobe.
- Sits between the register bank (enable, durations) and the ADC start/done handshake in the DMM top level.

Parameters:
AZMUX_HI, 4'b0001, azmux code selecting the signal (precharge output) path
AZMUX_LO, 4'b0010, azmux code selecting the LO / zero reference
START_CYCLES, 2, number of cycles adc_measure_start is held high per trigger (≥2)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  run auto-zero cycling while high
clk_settle_duration  in  32  settle cycles after mux switch, before ADC trigger
clk_timeout  in  32  max cycles from trigger to done rising edge; 0 = no timeout
adc_measure_done  in  1  done flag from ADC block
adc_measure_start  out  1  trigger to ADC block
azmux  out  4  auto-zero input mux select
pc_sw  out  1  precharge switch, high during HI phase
sample_valid  out  1  one-cycle strobe when a phase's conversion completes
sample_phase  out  1  phase of last completed conversion: 1 = HI, 0 = LO
az_count  out  32  completed HI+LO pairs, wraps at 2^32
error  out  1  sticky timeout flag
monitor  out  4  debug: {error, sample_valid, adc_measure_start, phase}

Behaviour:
- All state updates occur on posedge clk.
- Reset takes priority over every other input and aborts any operation immediately, including a mid-measurement cycle.
- Reset values:
  - state = IDLE
  - adc_measure_start = 0, sample_valid = 0, sample_phase = 0
  - azmux = AZMUX_LO, pc_sw = 0
  - az_count = 0, error = 0, monitor = 0
  - internal phase = HI, done_prev = 1
- done_prev registers adc_measure_done every cycle. A rising edge is done_prev == 0 && adc_measure_done == 1.
  - Done idles high after ADC reset and idles low after its first measurement; only a rising edge counts as completion, never the level.
- States:
  - IDLE: azmux = AZMUX_LO, pc_sw = 0. If enable && !error: phase <= HI, go SWITCH.
  - SWITCH (1 cycle):
    - phase HI: azmux = AZMUX_HI, pc_sw = 1. Phase LO: azmux = AZMUX_LO, pc_sw = 0.
    - Load the settle counter with clk_settle_duration. Go SETTLE.
  - SETTLE: decrement the counter each cycle; when counter == 0, go START. SETTLE lasts clk_settle_duration + 1 cycles; duration 0 gives 1 cycle.
  - START:
    - adc_measure_start = 1 for exactly START_CYCLES consecutive cycles.
    - Load the timeout counter with clk_timeout on entry.
    - Then start = 0 and go WAIT.
    - Start must be low again before the ADC returns to its wait-for-start state, so no retrigger occurs.
  - WAIT:
    - start = 0. The timeout counter decrements from START entry.
    - On a done rising edge, go DONE. A rising edge during START is also latched and honoured.
    - If clk_timeout != 0 and the counter reaches 0 with no edge: error <= 1, go IDLE.
  - DONE (1 cycle):
    - sample_valid = 1, sample_phase = phase.
    - If phase == LO: az_count <= az_count + 1, wrapping.
    - Toggle phase. If enable: go SWITCH. Otherwise go IDLE.
- enable falling mid-sequence does not abort: the current phase runs to DONE (the ADC has no abort), then the block enters IDLE. The cycle after DONE, azmux = AZMUX_LO.
- Once set, error persists until reset. IDLE does not restart while error = 1.
- Timing while enable stays high:
  - Latency from enable rising in IDLE to the first start pulse = 2 + clk_settle_duration + 1 cycles.
  - Mux settings are held constant from SWITCH through DONE, so the ADC never sees a mux change mid-conversion.

Test Plan:
- Reset, then enable = 1, settle = 3, ADC model with sample duration 10 -> azmux = AZMUX_HI, pc_sw = 1; start high 2 cycles, starting 6 cycles after enable; sample_valid with sample_phase = 1; then LO phase with sample_phase = 0 and az_count = 1.
- Run 4 full pairs -> sample_phase alternates 1,0,1,0,…; az_count = 4; azmux never changes while start is high or before done rises.
- Deassert enable in the middle of the HI-phase WAIT -> HI conversion completes (sample_valid, phase 1), then IDLE with azmux = AZMUX_LO, pc_sw = 0, no further start pulses.
- ADC model never raises done, clk_timeout = 20 -> error = 1 exactly 20 cycles after START entry; block stays in IDLE despite enable = 1 until reset.
- ADC done held at 1 after reset (first measurement) -> no false completion; completion only on the 0→1 edge; clk_timeout = 0 with a stuck ADC -> waits indefinitely, error stays 0.
- Assert reset during SETTLE and again during WAIT -> next cycle all outputs at reset values; az_count = 0; resequencing starts from the HI phase.

Source files
------------

// File: rtl/az_sequencer_if.sv
// Auto-zero sequencer bus: register-bank configuration, ADC start/done
// handshake and the mux / sample outputs, bundled for the DMM top level.
interface az_sequencer_if;
   logic        enable;
   logic [31:0] clk_settle_duration;
   logic [31:0] clk_timeout;
   logic        adc_measure_done;
   logic        adc_measure_start;
   logic [3:0]  azmux;
   logic        pc_sw;
   logic        sample_valid;
   logic        sample_phase;
   logic [31:0] az_count;
   logic        error;
   logic [3:0]  monitor;

   // Register bank / ADC side
   modport master (
      output enable, clk_settle_duration, clk_timeout, adc_measure_done,
      input  adc_measure_start, azmux, pc_sw, sample_valid, sample_phase,
             az_count, error, monitor
   );

   // Sequencer side
   modport slave (
      input  enable, clk_settle_duration, clk_timeout, adc_measure_done,
      output adc_measure_start, azmux, pc_sw, sample_valid, sample_phase,
             az_count, error, monitor
   );
endinterface

// File: rtl/az_sequencer.sv
// Auto-zero sequencer: alternates HI (signal) and LO (zero) conversions,
// switching the input mux, waiting out the settle time, triggering the ADC
// and strobing each completed conversion.
//
// state    | meaning
// ---------+---------------------------------------------------------
// S_IDLE   | mux on LO, precharge off; waits for enable with no error
// S_SWITCH | mux/precharge set for the current phase, settle loaded
// S_SETTLE | settle countdown, clk_settle_duration + 1 cycles
// S_START  | adc_measure_start held high for START_CYCLES cycles
// S_WAIT   | waiting for a done rising edge, optional timeout
// S_DONE   | sample strobe, pair count, phase toggle
module az_sequencer #(
   parameter logic [3:0] AZMUX_HI     = 4'b0001,
   parameter logic [3:0] AZMUX_LO     = 4'b0010,
   parameter int         START_CYCLES = 2
) (
   input logic          clk,
   input logic          reset,
   az_sequencer_if.slave bus
);

   localparam int SCW = $clog2(START_CYCLES + 1);
   localparam logic [SCW-1:0] START_LAST = SCW'(START_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_SWITCH, S_SETTLE, S_START, S_WAIT, S_DONE
   } state_t;

   typedef enum logic {PH_LO = 1'b0, PH_HI = 1'b1} phase_t;

   state_t         state, state_next;
   phase_t         phase;
   logic           done_prev;
   logic           done_seen;
   logic           done_rise;
   logic           timeout_hit;
   logic [31:0]    settle_cnt;
   logic [31:0]    to_cnt;
   logic [SCW-1:0] start_cnt;
   logic           sample_phase_q;
   logic [31:0]    az_count_q;
   logic           error_q;

   // Only a 0->1 transition of done counts; the level is ambiguous after ADC reset.
   assign done_rise = !done_prev && bus.adc_measure_done;

   // The counter is loaded at START entry; firing at 1 lands the error
   // exactly clk_timeout cycles after entry.
   assign timeout_hit = (state == S_WAIT) && (bus.clk_timeout != 32'd0) &&
                        (to_cnt <= 32'd1) && !done_rise && !done_seen;

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   // Next-state and phase-derived outputs
   always_comb begin
      state_next            = state;
      bus.adc_measure_start = 1'b0;
      bus.sample_valid      = 1'b0;
      bus.azmux             = AZMUX_LO;
      bus.pc_sw             = 1'b0;
      case (state)
         S_IDLE:   if (bus.enable && !error_q) state_next = S_SWITCH;
         S_SWITCH: state_next = S_SETTLE;
         S_SETTLE: if (settle_cnt == 32'd0) state_next = S_START;
         S_START: begin
            bus.adc_measure_start = 1'b1;
            if (start_cnt == START_LAST) state_next = S_WAIT;
         end
         S_WAIT: begin
            if (done_rise || done_seen) state_next = S_DONE;
            else if (timeout_hit)       state_next = S_IDLE;
         end
         S_DONE: begin
            bus.sample_valid = 1'b1;
            state_next       = bus.enable ? S_SWITCH : S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
      // Mux is a function of phase only, so it cannot move between SWITCH and DONE.
      if (state != S_IDLE && phase == PH_HI) begin
         bus.azmux = AZMUX_HI;
         bus.pc_sw = 1'b1;
      end
   end

   // Counters, phase, done edge tracking and sticky status
   always_ff @(posedge clk) begin
      if (reset) begin
         phase          <= PH_HI;
         done_prev      <= 1'b1;
         done_seen      <= 1'b0;
         settle_cnt     <= 32'd0;
         to_cnt         <= 32'd0;
         start_cnt      <= '0;
         sample_phase_q <= 1'b0;
         az_count_q     <= 32'd0;
         error_q        <= 1'b0;
      end else begin
         done_prev <= bus.adc_measure_done;
         case (state)
            S_IDLE: if (state_next == S_SWITCH) phase <= PH_HI;
            S_SWITCH: settle_cnt <= bus.clk_settle_duration;
            S_SETTLE: begin
               if (settle_cnt != 32'd0) begin
                  settle_cnt <= settle_cnt - 32'd1;
               end else begin
                  to_cnt    <= bus.clk_timeout;
                  start_cnt <= '0;
                  done_seen <= 1'b0;
               end
            end
            S_START: begin
               start_cnt <= start_cnt + 1'b1;
               if (to_cnt != 32'd0) to_cnt <= to_cnt - 32'd1;
               // ADC may finish fast; keep the edge for WAIT.
               if (done_rise) done_seen <= 1'b1;
            end
            S_WAIT: begin
               if (to_cnt != 32'd0) to_cnt <= to_cnt - 32'd1;
               if (done_rise || done_seen) sample_phase_q <= phase;
               if (timeout_hit) error_q <= 1'b1;
            end
            S_DONE: begin
               if (phase == PH_LO) az_count_q <= az_count_q + 32'd1;
               phase <= (phase == PH_HI) ? PH_LO : PH_HI;
            end
            default: ;
         endcase
      end
   end

   assign bus.sample_phase = sample_phase_q;
   assign bus.az_count     = az_count_q;
   assign bus.error        = error_q;
   // Phase bit is masked in IDLE so the debug word reads zero out of reset.
   assign bus.monitor      = {error_q, bus.sample_valid, bus.adc_measure_start,
                              (state != S_IDLE) && (phase == PH_HI)};

endmodule

// File: tb/tb_az_sequencer.sv
// Bench for az_sequencer: ADC behavioural model, event recorder and one
// task per scenario with directed expectations.
module tb_az_sequencer;

   localparam logic [3:0] AZ_HI   = 4'b0001;
   localparam logic [3:0] AZ_LO   = 4'b0010;
   localparam int         ADC_DUR = 10;

   logic clk = 1'b0;
   logic reset;
   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   az_sequencer_if bus ();

   az_sequencer dut (.clk(clk), .reset(reset), .bus(bus));

   // ADC model: done idles high after reset, drops on start, pulses high
   // after ADC_DUR cycles, then idles low.
   logic model_done;
   int   m_state;
   int   m_cnt;
   logic ovr_en  = 1'b0;
   logic ovr_val = 1'b0;

   assign bus.adc_measure_done = ovr_en ? ovr_val : model_done;

   always @(posedge clk) begin
      if (reset) begin
         model_done <= 1'b1;
         m_state    <= 0;
         m_cnt      <= 0;
      end else begin
         case (m_state)
            0: if (bus.adc_measure_start) begin
               model_done <= 1'b0;
               m_cnt      <= ADC_DUR - 1;
               m_state    <= 1;
            end
            1: if (m_cnt == 0) begin
               model_done <= 1'b1;
               m_state    <= 2;
            end else begin
               m_cnt <= m_cnt - 1;
            end
            default: begin
               model_done <= 1'b0;
               m_state    <= 0;
            end
         endcase
      end
   end

   // Event recorder, sampled on the falling edge
   logic sv_q[$];
   int   start_cyc_q[$];
   int   start_len_q[$];
   int   cur_len;
   int   mux_viol;
   logic busy;
   logic [3:0] prev_mux;
   logic prev_start;
   logic err_prev;
   logic err_seen;
   int   err_cyc;

   always @(negedge clk) begin
      if (busy && bus.azmux !== prev_mux) mux_viol++;
      if (bus.adc_measure_start === 1'b1) begin
         busy = 1'b1;
         if (prev_start !== 1'b1) start_cyc_q.push_back(cyc);
         cur_len++;
      end else if (cur_len > 0) begin
         start_len_q.push_back(cur_len);
         cur_len = 0;
      end
      if (bus.sample_valid === 1'b1) begin
         sv_q.push_back(bus.sample_phase);
         busy = 1'b0;
      end
      if (bus.error === 1'b1 && err_prev !== 1'b1 && !err_seen) begin
         err_seen = 1'b1;
         err_cyc  = cyc;
      end
      err_prev   = bus.error;
      prev_start = bus.adc_measure_start;
      prev_mux   = bus.azmux;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_rec();
      sv_q.delete();
      start_cyc_q.delete();
      start_len_q.delete();
      cur_len  = 0;
      mux_viol = 0;
      busy     = 1'b0;
      err_seen = 1'b0;
      err_cyc  = 0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      clear_rec();
   endtask

   task automatic wait_valid(input int n, input int budget, input string name);
      int k = 0;
      while (sv_q.size() < n && k < budget) begin
         tick(1);
         k++;
      end
      tests++;
      if (sv_q.size() < n) begin
         fails++;
         $display("FAIL %s: got %0d sample_valid strobes, need %0d", name, sv_q.size(), n);
      end
   endtask

   task automatic wait_starts(input int n, input int budget, input string name);
      int k = 0;
      while (start_len_q.size() < n && k < budget) begin
         tick(1);
         k++;
      end
      tests++;
      if (start_len_q.size() < n) begin
         fails++;
         $display("FAIL %s: got %0d start pulses, need %0d", name, start_len_q.size(), n);
      end
   endtask

   task automatic test_reset();
      bus.enable = 1'b0;
      bus.clk_settle_duration = 32'd3;
      bus.clk_timeout = 32'd0;
      ovr_en = 1'b0;
      do_reset();
      tests++; if (bus.adc_measure_start !== 1'b0) begin fails++; $display("FAIL rst_start: got %b exp 0", bus.adc_measure_start); end
      tests++; if (bus.sample_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b exp 0", bus.sample_valid); end
      tests++; if (bus.sample_phase !== 1'b0) begin fails++; $display("FAIL rst_phase: got %b exp 0", bus.sample_phase); end
      tests++; if (bus.azmux !== AZ_LO) begin fails++; $display("FAIL rst_azmux: got %h exp %h", bus.azmux, AZ_LO); end
      tests++; if (bus.pc_sw !== 1'b0) begin fails++; $display("FAIL rst_pc_sw: got %b exp 0", bus.pc_sw); end
      tests++; if (bus.az_count !== 32'd0) begin fails++; $display("FAIL rst_count: got %0d exp 0", bus.az_count); end
      tests++; if (bus.error !== 1'b0) begin fails++; $display("FAIL rst_error: got %b exp 0", bus.error); end
      tests++; if (bus.monitor !== 4'b0000) begin fails++; $display("FAIL rst_monitor: got %b exp 0000", bus.monitor); end
   endtask

   task automatic test_first_pair();
      do_reset();
      bus.enable = 1'b1;
      tick(5);
      tests++; if (bus.adc_measure_start !== 1'b0) begin fails++; $display("FAIL fp_early_start: got %b exp 0", bus.adc_measure_start); end
      tests++; if (bus.azmux !== AZ_HI) begin fails++; $display("FAIL fp_azmux_hi: got %h exp %h", bus.azmux, AZ_HI); end
      tick(1);
      tests++; if (bus.adc_measure_start !== 1'b1) begin fails++; $display("FAIL fp_start_at6: got %b exp 1", bus.adc_measure_start); end
      tests++; if (bus.pc_sw !== 1'b1) begin fails++; $display("FAIL fp_pc_sw: got %b exp 1", bus.pc_sw); end
      tests++; if (bus.monitor !== 4'b0011) begin fails++; $display("FAIL fp_monitor: got %b exp 0011", bus.monitor); end
      tick(1);
      tests++; if (bus.adc_measure_start !== 1'b1) begin fails++; $display("FAIL fp_start_2nd: got %b exp 1", bus.adc_measure_start); end
      tick(1);
      tests++; if (bus.adc_measure_start !== 1'b0) begin fails++; $display("FAIL fp_start_end: got %b exp 0", bus.adc_measure_start); end
      wait_valid(2, 100, "fp_wait");
      tests++; if (((sv_q.size() > 0) ? sv_q[0] : 1'bx) !== 1'b1) begin fails++; $display("FAIL fp_phase0: got %b exp 1", (sv_q.size() > 0) ? sv_q[0] : 1'bx); end
      tests++; if (((sv_q.size() > 1) ? sv_q[1] : 1'bx) !== 1'b0) begin fails++; $display("FAIL fp_phase1: got %b exp 0", (sv_q.size() > 1) ? sv_q[1] : 1'bx); end
      tick(2);
      tests++; if (bus.az_count !== 32'd1) begin fails++; $display("FAIL fp_count: got %0d exp 1", bus.az_count); end
      bus.enable = 1'b0;
   endtask

   task automatic test_four_pairs();
      do_reset();
      bus.enable = 1'b1;
      wait_valid(8, 400, "fourp_wait");
      for (int i = 0; i < 8; i++) begin
         tests++;
         if (((sv_q.size() > i) ? sv_q[i] : 1'bx) !== ((i % 2 == 0) ? 1'b1 : 1'b0)) begin
            fails++;
            $display("FAIL fourp_phase[%0d]: got %b exp %b", i, (sv_q.size() > i) ? sv_q[i] : 1'bx, (i % 2 == 0));
         end
      end
      tick(2);
      tests++; if (bus.az_count !== 32'd4) begin fails++; $display("FAIL fourp_count: got %0d exp 4", bus.az_count); end
      tests++; if (mux_viol !== 0) begin fails++; $display("FAIL fourp_mux_stable: got %0d changes exp 0", mux_viol); end
      for (int i = 0; i < start_len_q.size(); i++) begin
         tests++;
         if (start_len_q[i] !== 2) begin fails++; $display("FAIL fourp_start_len[%0d]: got %0d exp 2", i, start_len_q[i]); end
      end
      bus.enable = 1'b0;
   endtask

   task automatic test_enable_drop();
      do_reset();
      bus.enable = 1'b1;
      wait_starts(1, 40, "drop_start");
      tick(3);
      bus.enable = 1'b0;
      wait_valid(1, 50, "drop_wait");
      tests++; if (((sv_q.size() > 0) ? sv_q[0] : 1'bx) !== 1'b1) begin fails++; $display("FAIL drop_phase: got %b exp 1", (sv_q.size() > 0) ? sv_q[0] : 1'bx); end
      tick(2);
      tests++; if (bus.azmux !== AZ_LO) begin fails++; $display("FAIL drop_azmux: got %h exp %h", bus.azmux, AZ_LO); end
      tests++; if (bus.pc_sw !== 1'b0) begin fails++; $display("FAIL drop_pc_sw: got %b exp 0", bus.pc_sw); end
      tick(60);
      tests++; if (start_len_q.size() !== 1) begin fails++; $display("FAIL drop_no_restart: got %0d pulses exp 1", start_len_q.size()); end
      tests++; if (sv_q.size() !== 1) begin fails++; $display("FAIL drop_valids: got %0d exp 1", sv_q.size()); end
      tests++; if (bus.az_count !== 32'd0) begin fails++; $display("FAIL drop_count: got %0d exp 0", bus.az_count); end
   endtask

   task automatic test_timeout();
      int k = 0;
      ovr_en  = 1'b1;
      ovr_val = 1'b0;
      bus.clk_timeout = 32'd20;
      do_reset();
      bus.enable = 1'b1;
      while (!err_seen && k < 80) begin
         tick(1);
         k++;
      end
      tests++; if (err_seen !== 1'b1) begin fails++; $display("FAIL to_error_set: got %b exp 1", err_seen); end
      tests++;
      if ((err_cyc - ((start_cyc_q.size() > 0) ? start_cyc_q[0] : 0)) !== 20) begin
         fails++;
         $display("FAIL to_latency: got %0d cycles exp 20", err_cyc - ((start_cyc_q.size() > 0) ? start_cyc_q[0] : 0));
      end
      tick(50);
      tests++; if (start_cyc_q.size() !== 1) begin fails++; $display("FAIL to_no_restart: got %0d pulses exp 1", start_cyc_q.size()); end
      tests++; if (bus.error !== 1'b1) begin fails++; $display("FAIL to_sticky: got %b exp 1", bus.error); end
      tests++; if (bus.azmux !== AZ_LO) begin fails++; $display("FAIL to_azmux: got %h exp %h", bus.azmux, AZ_LO); end
      tests++; if (sv_q.size() !== 0) begin fails++; $display("FAIL to_valids: got %0d exp 0", sv_q.size()); end
      do_reset();
      tests++; if (bus.error !== 1'b0) begin fails++; $display("FAIL to_reset_clears: got %b exp 0", bus.error); end
      bus.enable = 1'b0;
      bus.clk_timeout = 32'd0;
      ovr_en = 1'b0;
   endtask

   task automatic test_done_level();
      ovr_en  = 1'b1;
      ovr_val = 1'b1;
      bus.clk_timeout = 32'd0;
      do_reset();
      bus.enable = 1'b1;
      tick(60);
      tests++; if (sv_q.size() !== 0) begin fails++; $display("FAIL lvl_high_no_valid: got %0d exp 0", sv_q.size()); end
      tests++; if (start_len_q.size() !== 1) begin fails++; $display("FAIL lvl_one_start: got %0d exp 1", start_len_q.size()); end
      ovr_val = 1'b0;
      tick(40);
      tests++; if (sv_q.size() !== 0) begin fails++; $display("FAIL lvl_low_no_valid: got %0d exp 0", sv_q.size()); end
      tests++; if (bus.error !== 1'b0) begin fails++; $display("FAIL lvl_no_timeout: got %b exp 0", bus.error); end
      ovr_val = 1'b1;
      wait_valid(1, 5, "lvl_edge");
      tests++; if (((sv_q.size() > 0) ? sv_q[0] : 1'bx) !== 1'b1) begin fails++; $display("FAIL lvl_phase: got %b exp 1", (sv_q.size() > 0) ? sv_q[0] : 1'bx); end
      bus.enable = 1'b0;
      ovr_en = 1'b0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      bus.enable = 1'b1;
      tick(3);
      reset = 1'b1;
      tick(1);
      tests++; if (bus.azmux !== AZ_LO) begin fails++; $display("FAIL rs_settle_azmux: got %h exp %h", bus.azmux, AZ_LO); end
      tests++; if (bus.pc_sw !== 1'b0) begin fails++; $display("FAIL rs_settle_pc_sw: got %b exp 0", bus.pc_sw); end
      tests++; if (bus.monitor !== 4'b0000) begin fails++; $display("FAIL rs_settle_monitor: got %b exp 0000", bus.monitor); end
      reset = 1'b0;
      clear_rec();
      wait_starts(3, 120, "rs_wait_starts");
      tick(2);
      tests++; if (bus.az_count !== 32'd1) begin fails++; $display("FAIL rs_pre_count: got %0d exp 1", bus.az_count); end
      tests++; if (bus.azmux !== AZ_HI) begin fails++; $display("FAIL rs_pre_azmux: got %h exp %h", bus.azmux, AZ_HI); end
      reset = 1'b1;
      tick(1);
      tests++; if (bus.az_count !== 32'd0) begin fails++; $display("FAIL rs_wait_count: got %0d exp 0", bus.az_count); end
      tests++; if (bus.azmux !== AZ_LO) begin fails++; $display("FAIL rs_wait_azmux: got %h exp %h", bus.azmux, AZ_LO); end
      tests++; if (bus.adc_measure_start !== 1'b0) begin fails++; $display("FAIL rs_wait_start: got %b exp 0", bus.adc_measure_start); end
      tests++; if (bus.sample_phase !== 1'b0) begin fails++; $display("FAIL rs_wait_phase: got %b exp 0", bus.sample_phase); end
      tests++; if (bus.monitor !== 4'b0000) begin fails++; $display("FAIL rs_wait_monitor: got %b exp 0000", bus.monitor); end
      reset = 1'b0;
      clear_rec();
      wait_valid(1, 60, "rs_resume");
      tests++; if (((sv_q.size() > 0) ? sv_q[0] : 1'bx) !== 1'b1) begin fails++; $display("FAIL rs_resume_phase: got %b exp 1", (sv_q.size() > 0) ? sv_q[0] : 1'bx); end
      bus.enable = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      bus.enable = 1'b0;
      bus.clk_settle_duration = 32'd3;
      bus.clk_timeout = 32'd0;
      clear_rec();
      test_reset();
      test_first_pair();
      test_four_pairs();
      test_enable_drop();
      test_timeout();
      test_done_level();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d fails=%0d", tests, fails);
      $fatal(1, "watchdog");
   end

endmodule
